fetch_dispatch_fsm: RTL

Instruction fetch/decode front end that sits directly upstream of the ALU-immediate FSM and its sibling execution FSMs. It owns the PC and fetches a 16-bit word from instruction memory. It decodes the instruction class and presents the word on `instruction`, then pulses a one-hot start to the matching execution unit and waits for that unit's `done`. It applies `pcInc`/`pcLoad` requests from the active unit, and traps on halt, illegal class, or execution timeout.

---
 rtl/fetch_dispatch_fsm_pkg.sv | 59 +++++
 rtl/fetch_dispatch_fsm_pc_reg.sv | 26 ++
 rtl/fetch_dispatch_fsm.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_dispatch_fsm_pkg.sv
// rtl/fetch_dispatch_fsm_pkg.sv - shared class codes, unit indices, fault codes and state encoding
package fetch_dispatch_fsm_pkg;

  // Instruction class codes, taken from instruction[15:12]
  localparam logic [3:0] CLS_ALUI = 4'h0;
  localparam logic [3:0] CLS_ALU  = 4'h1;
  localparam logic [3:0] CLS_LD   = 4'h2;
  localparam logic [3:0] CLS_ST   = 4'h3;
  localparam logic [3:0] CLS_BR   = 4'h4;
  localparam logic [3:0] CLS_HALT = 4'hF;

  // Execution unit indices; bit position in unitStart/unitDone
  localparam logic [1:0] UNIT_ALUI = 2'd0;
  localparam logic [1:0] UNIT_ALU  = 2'd1;
  localparam logic [1:0] UNIT_LS   = 2'd2;
  localparam logic [1:0] UNIT_BR   = 2'd3;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_e;

  // State encoding kept as plain constants so older code can compare raw values
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_DISPATCH = 3'd3;
  localparam logic [2:0] ST_EXEC     = 3'd4;
  localparam logic [2:0] ST_HALTED   = 3'd5;
  localparam logic [2:0] ST_FAULT    = 3'd6;

  typedef struct packed {
    logic       legal;
    logic       halt;
    logic [1:0] unit;
  } cls_dec_t;

  // Map a class code to its execution unit; halt is reported separately and is not "legal"
  function automatic cls_dec_t decode_class(input logic [3:0] cls);
    cls_dec_t d;
    d.legal = 1'b1;
    d.halt  = 1'b0;
    d.unit  = UNIT_ALUI;
    case (cls)
      CLS_ALUI:       d.unit = UNIT_ALUI;
      CLS_ALU:        d.unit = UNIT_ALU;
      CLS_LD, CLS_ST: d.unit = UNIT_LS;
      CLS_BR:         d.unit = UNIT_BR;
      CLS_HALT: begin
        d.legal = 1'b0;
        d.halt  = 1'b1;
      end
      default:        d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fetch_dispatch_fsm_pc_reg.sv
// rtl/fetch_dispatch_fsm_pc_reg.sv - program counter with load-over-increment priority and wrap
module fetch_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // Updates only while enabled; load beats inc, inc wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (en && load) begin
      pc <= load_val;
    end else if (en && inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// rtl/fetch_dispatch_fsm.sv - instruction fetch, class decode and one-hot unit dispatch front end
module fetch_dispatch_fsm
  import fetch_dispatch_fsm_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRead,
  input  logic [15:0]       memData,
  input  logic              memValid,
  output logic [15:0]       instruction,
  output logic [3:0]        unitStart,
  input  logic [3:0]        unitDone,
  input  logic              pcInc,
  input  logic              pcLoad,
  input  logic [ADDR_W-1:0] pcLoadVal,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        faultCode,
  output logic [15:0]       retireCount
);

  // Watchdog counts EXEC cycles 0..TIMEOUT-1; the last value is the final chance for done
  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [1:0]      unit_idx;
  logic [WD_W-1:0] watchdog;
  fault_code_e     fault_code;
  cls_dec_t        dec;
  logic [ADDR_W-1:0] pc;

  // Decode the held instruction; only consumed while in DECODE
  always_comb begin
    dec = decode_class(instruction[15:12]);
  end

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_EXEC),
    .inc      (pcInc),
    .load     (pcLoad),
    .load_val (pcLoadVal),
    .pc       (pc)
  );

  // Main sequencer: fetch, decode, dispatch, wait for done, trap on halt/illegal/timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      instruction <= '0;
      unit_idx    <= UNIT_ALUI;
      watchdog    <= '0;
      fault_code  <= FC_NONE;
      retireCount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (memValid) begin
            instruction <= memData;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec.halt) begin
            state <= ST_HALTED;
          end else if (!dec.legal) begin
            fault_code <= FC_ILLEGAL;
            state      <= ST_FAULT;
          end else begin
            unit_idx <= dec.unit;
            state    <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          watchdog <= '0;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          if (unitDone[unit_idx]) begin
            retireCount <= retireCount + 16'd1;
            state       <= run ? ST_FETCH : ST_IDLE;
          end else if (watchdog == WD_LAST) begin
            fault_code <= FC_TIMEOUT;
            state      <= ST_FAULT;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Strobes derive from state so they drop the instant reset asserts
  always_comb begin
    memAddr   = pc;
    memRead   = (state == ST_FETCH);
    unitStart = (state == ST_DISPATCH) ? (4'b0001 << unit_idx) : 4'b0000;
    halted    = (state == ST_HALTED);
    fault     = (state == ST_FAULT);
    faultCode = fault_code;
  end

endmodule
